// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM encoding, round-constant table and the
// GF(2^8) column/row transforms used by the iterative round datapath.
package aes_pkg;

  localparam int unsigned AES_NR = 10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ROUND = 2'd1;
  localparam state_t ST_FINAL = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Column word is {row0, row1, row2, row3}.
  function automatic logic [31:0] mix_column(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
    return r;
  endfunction

  // Byte n sits at row n%4, column n/4; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c+w)%4)) -: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aes128_key_step.sv
// One step of the AES-128 key schedule: derives the next round key from the current one.
module aes128_key_step (
  input  logic [127:0] i_rk,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_rk
);

  logic [31:0] w_rot;
  logic [31:0] w_sub;
  logic [31:0] w_t;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign w_rot = {i_rk[23:0], i_rk[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_rot[31-8*g -: 8]),
      .o_byte (w_sub[31-8*g -: 8])
    );
  end

  assign w_t  = w_sub ^ {i_rcon, 24'h000000};
  assign w_n0 = i_rk[127:96] ^ w_t;
  assign w_n1 = i_rk[95:64]  ^ w_n0;
  assign w_n2 = i_rk[63:32]  ^ w_n1;
  assign w_n3 = i_rk[31:0]   ^ w_n2;
  assign o_rk = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_sbox.sv
// AES S-box: multiplicative inverse in GF(2^8) followed by the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  logic [7:0] w_sq;
  logic [7:0] w_inv;

  // x^254 = x^2 * x^4 * ... * x^128, which also maps 0 to 0.
  always_comb begin
    w_sq  = i_byte;
    w_inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      w_sq  = gf_mul(w_sq, w_sq);
      w_inv = gf_mul(w_inv, w_sq);
    end
  end

  assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes_sub_bytes.sv
// SubBytes over the full 128-bit state; passes the state through when i_ctrl is low.
module aes_sub_bytes (
  input  logic         i_ctrl,
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  logic [127:0] w_sub;

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (i_state[127-8*g -: 8]),
      .o_byte (w_sub[127-8*g -: 8])
    );
  end

  assign o_state = i_ctrl ? w_sub : i_state;

endmodule

// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryptor: one shared round datapath, one round per clock,
// valid/ready handshakes on the plaintext/key input and the ciphertext output.
module aes128_round_sequencer
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic [3:0]   round_idx
);

  if (NR != AES_NR) begin : g_nr_check
    $error("aes128_round_sequencer: NR must be 10");
  end

  state_t       r_state;
  logic [127:0] r_st;
  logic [127:0] r_rk;
  logic [127:0] r_ct;
  logic [3:0]   r_round;
  logic         r_out_valid;

  logic         w_sb_ctrl;
  logic [127:0] w_sb;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_nrk;
  logic [127:0] w_round_out;

  assign w_sb_ctrl = (r_state == ST_ROUND) || (r_state == ST_FINAL);

  aes_sub_bytes u_sub_bytes (
    .i_ctrl  (w_sb_ctrl),
    .i_state (r_st),
    .o_state (w_sb)
  );

  aes128_key_step u_key_step (
    .i_rk   (r_rk),
    .i_rcon (rcon(r_round)),
    .o_rk   (w_nrk)
  );

  assign w_sr        = shift_rows(w_sb);
  assign w_mc        = mix_columns(w_sr);
  // The last round skips MixColumns.
  assign w_round_out = ((r_state == ST_FINAL) ? w_sr : w_mc) ^ w_nrk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_st        <= '0;
      r_rk        <= '0;
      r_ct        <= '0;
      r_round     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_st    <= plaintext ^ key;
            r_rk    <= key;
            r_round <= 4'd1;
            r_state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_st    <= w_round_out;
          r_rk    <= w_nrk;
          r_round <= r_round + 4'd1;
          if (r_round == 4'd9) r_state <= ST_FINAL;
        end
        ST_FINAL: begin
          r_st        <= w_round_out;
          r_rk        <= w_nrk;
          r_ct        <= w_round_out;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_round     <= '0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign out_valid  = r_out_valid;
  assign ciphertext = r_ct;
  assign round_idx  = r_round;

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Bench for aes128_round_sequencer: FIPS-197 vectors plus random blocks checked
// against a byte-array AES reference built from log/antilog tables.
module tb_aes128_round_sequencer;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;
  logic [3:0]   round_idx;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

  aes128_round_sequencer #(.NR(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy),
    .round_idx  (round_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] gf_exp [256];
  logic [7:0] gf_log [256];
  logic [7:0] sbox_tbl [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] e;
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    e = 8'h01;
    c = 8'h63;
    for (int i = 0; i < 255; i++) begin
      gf_exp[i] = e;
      gf_log[e] = 8'(i);
      e = e ^ xt(e);  // generator 0x03
    end
    for (int x = 0; x < 256; x++) begin
      if (x == 0) inv = 8'h00;
      else inv = gf_exp[(255 - int'(gf_log[x])) % 255];
      for (int b = 0; b < 8; b++) begin
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      end
      sbox_tbl[x] = s;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tbl[tmp[31:24]], sbox_tbl[tmp[23:16]], sbox_tbl[tmp[15:8]], sbox_tbl[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_tbl[s[i]];
      for (int rr = 0; rr < 4; rr++)
        for (int cc = 0; cc < 4; cc++) t[rr+4*cc] = s[rr+4*((cc+rr)%4)];
      for (int cc = 0; cc < 4; cc++) begin
        a0 = t[4*cc]; a1 = t[4*cc+1]; a2 = t[4*cc+2]; a3 = t[4*cc+3];
        if (rnd < 10) begin
          s[4*cc]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*cc+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*cc+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*cc+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4*cc] = a0; s[4*cc+1] = a1; s[4*cc+2] = a2; s[4*cc+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    check_eq({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    check_eq({tag, "_busy"}, 128'(busy), 128'd0);
    check_eq({tag, "_round_idx"}, 128'(round_idx), 128'd0);
  endtask

  // Accept edge is counted as edge 1; out_valid must appear after edge 11.
  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] exp, input int hold, input bit toggle,
                           input bit chk_rounds);
    int edges;
    plaintext = pt;
    key       = k;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges    = 1;
    while (!out_valid && edges < 40) begin
      if (chk_rounds)
        check_eq({tag, "_round_idx"}, 128'(round_idx), 128'((edges > 10) ? 10 : edges));
      if (toggle) begin
        plaintext = rand128();
        key       = rand128();
        in_valid  = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      edges++;
    end
    in_valid = 1'b0;
    check_eq({tag, "_latency"}, 128'(edges), 128'd11);
    check_eq({tag, "_ct"}, ciphertext, exp);
    check_eq({tag, "_final_round_idx"}, 128'(round_idx), 128'd10);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (chk_rounds || h == hold - 1) begin
        check_eq({tag, "_hold_valid"}, 128'(out_valid), 128'd1);
        check_eq({tag, "_hold_ct"}, ciphertext, exp);
        check_eq({tag, "_hold_in_ready"}, 128'(in_ready), 128'd0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_idle({tag, "_after_hs"});
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_out_seen"}, 128'(out_valid), 128'd1);
  endtask

  initial begin
    build_tables();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    key       = '0;
    #1;
    check_idle("reset");
    check_eq("reset_ct", ciphertext, 128'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // FIPS-197 C.1 and appendix B with round tracking.
    run_block("c1", PT1, K1, CT1, 1, 1'b0, 1'b1);
    run_block("b", PT2, K2, CT2, 1, 1'b0, 1'b1);

    // Output backpressure.
    run_block("bp", PT1, K1, CT1, 20, 1'b0, 1'b1);

    // Inputs wiggle while busy.
    run_block("toggle", PT1, K1, CT1, 2, 1'b1, 1'b0);

    // Back-to-back with in_valid held high.
    plaintext = PT1;
    key       = K1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    plaintext = PT2;
    key       = K2;
    wait_out("b2b1");
    check_eq("b2b1_ct", ciphertext, CT1);
    check_eq("b2b1_in_ready", 128'(in_ready), 128'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("b2b_gap_busy", 128'(busy), 128'd0);
    check_eq("b2b_gap_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("b2b2_busy", 128'(busy), 128'd1);
    check_eq("b2b2_round_idx", 128'(round_idx), 128'd1);
    wait_out("b2b2");
    check_eq("b2b2_ct", ciphertext, CT2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_idle("b2b_end");

    // Reset in the middle of round 5.
    plaintext = PT2;
    key       = K2;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 0; n < 20 && round_idx != 4'd5; n++) begin
      @(posedge clk); #1;
    end
    check_eq("mid_reached_r5", 128'(round_idx), 128'd5);
    rst = 1'b1;
    #1;
    check_idle("mid_reset");
    check_eq("mid_reset_ct", ciphertext, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_block("post_reset", PT1, K1, CT1, 0, 1'b0, 1'b0);

    // Random blocks against the reference model.
    for (int i = 0; i < 20; i++) begin
      logic [127:0] pt;
      logic [127:0] k;
      pt = rand128();
      k  = rand128();
      run_block("rand", pt, k, aes_ref(pt, k), $urandom_range(0, 3), 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
